// File: rtl/sram_bist_pkg.sv
// sram_bist_pkg: state encoding, March C- element table and background pattern helper
// shared by sram_march_bist and sram_bist_cmp.
package sram_bist_pkg;

   typedef enum logic [3:0] {IDLE, E0, E1, E2, E3, E4, E5, DRAIN, DONE} state_t;

   typedef struct packed {
      logic down;
      logic two_ops;
      logic rd_first;
      logic rpol;
      logic wpol;
   } elem_t;

   // Indexed by element 0..5; a one-op element with rd_first set is read-only.
   localparam elem_t ELEM [6] = '{
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1},
      '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},
      '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0}
   };

   function automatic logic bg_bit(input logic pass, input logic odd_addr, input logic odd_bit);
      return pass & ~(odd_addr ^ odd_bit);
   endfunction

endpackage

// File: rtl/sram_bist_cmp.sv
// sram_bist_cmp: READ_LAT-deep expected/valid pipeline aligned to the macro read latency,
// with capture of the first miscompare address and syndrome.
module sram_bist_cmp #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 6,
   parameter int READ_LAT = 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clr,
   input  logic              i_vld,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_exp,
   input  logic [DATA_W-1:0] i_dout,
   output logic              o_pass,
   output logic [ADDR_W-1:0] o_fail_addr,
   output logic [DATA_W-1:0] o_fail_syn
);

   logic              r_vld  [READ_LAT];
   logic [ADDR_W-1:0] r_addr [READ_LAT];
   logic [DATA_W-1:0] r_exp  [READ_LAT];
   logic [DATA_W-1:0] w_syn;
   logic              w_miss;

   assign w_syn  = r_exp[READ_LAT-1] ^ i_dout;
   assign w_miss = r_vld[READ_LAT-1] && (w_syn != '0);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < READ_LAT; i++) begin
            r_vld[i]  <= 1'b0;
            r_addr[i] <= '0;
            r_exp[i]  <= '0;
         end
      end else begin
         r_vld[0]  <= i_vld;
         r_addr[0] <= i_addr;
         r_exp[0]  <= i_exp;
         for (int i = 1; i < READ_LAT; i++) begin
            r_vld[i]  <= r_vld[i-1];
            r_addr[i] <= r_addr[i-1];
            r_exp[i]  <= r_exp[i-1];
         end
      end
   end

   // o_pass doubles as "nothing captured yet", so only the first miss is recorded.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_pass      <= 1'b1;
         o_fail_addr <= '0;
         o_fail_syn  <= '0;
      end else if (i_clr) begin
         o_pass      <= 1'b1;
         o_fail_addr <= '0;
         o_fail_syn  <= '0;
      end else if (w_miss && o_pass) begin
         o_pass      <= 1'b0;
         o_fail_addr <= r_addr[READ_LAT-1];
         o_fail_syn  <= w_syn;
      end
   end

endmodule

// File: rtl/sram_march_bist.sv
// sram_march_bist: March C- BIST engine driving a single-port bit-masked SRAM BIST port.
// Define SRAM_BIST_CHECKERBOARD_EN to repeat the march with a physical checkerboard background.
module sram_march_bist
   import sram_bist_pkg::*;
#(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 6,
   parameter int READ_LAT = 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              pass_o,
   output logic [ADDR_W-1:0] fail_addr_o,
   output logic [DATA_W-1:0] fail_syn_o,
   output logic              bist_en_o,
   output logic              bist_men_o,
   output logic              bist_wen_o,
   output logic              bist_ren_o,
   output logic [ADDR_W-1:0] bist_addr_o,
   output logic [DATA_W-1:0] bist_din_o,
   output logic [DATA_W-1:0] bist_bm_o,
   input  logic [DATA_W-1:0] bist_dout_i
);

`ifdef SRAM_BIST_CHECKERBOARD_EN
   localparam logic CB_EN = 1'b1;
`else
   localparam logic CB_EN = 1'b0;
`endif
   localparam logic [1:0] DRAIN_LAST = 2'(READ_LAT - 1);

   state_t            r_state, w_state_nx;
   logic [ADDR_W-1:0] r_addr, w_addr_nx, w_addr_step;
   logic              r_ph, w_ph_nx, r_bgp, w_bgp_nx, r_pass_q;
   logic [1:0]        r_dcnt, w_dcnt_nx;
   logic [2:0]        w_idx;
   elem_t             w_el;
   logic              w_op, w_rd, w_wr, w_last_op, w_wrap, w_start, w_pol, w_cmp_pass;
   logic [DATA_W-1:0] w_bg, w_word;

   assign w_op        = r_state inside {E0, E1, E2, E3, E4, E5};
   assign w_idx       = 3'(r_state) - 3'(E0);
   assign w_el        = w_op ? ELEM[w_idx] : '0;
   assign w_rd        = w_op && w_el.rd_first && !r_ph;
   assign w_wr        = w_op && !w_rd;
   assign w_last_op   = !w_el.two_ops || r_ph;
   assign w_addr_step = w_el.down ? r_addr - ADDR_W'(1) : r_addr + ADDR_W'(1);
   assign w_wrap      = w_el.down ? (r_addr == '0) : (r_addr == '1);
   assign w_pol       = w_rd ? w_el.rpol : w_el.wpol;
   assign w_start     = (r_state == IDLE) && start_i;
   assign w_word      = w_bg ^ {DATA_W{w_pol}};

   always_comb begin
      w_bg = '0;
      for (int i = 0; i < DATA_W; i++) w_bg[i] = bg_bit(r_bgp, r_addr[0], 1'(i));
   end

   // The last op of an element at its wrap address loads the next element's start address.
   always_comb begin
      w_state_nx = r_state;
      w_addr_nx  = r_addr;
      w_ph_nx    = r_ph;
      w_bgp_nx   = r_bgp;
      w_dcnt_nx  = r_dcnt;
      if (w_start) begin
         w_state_nx = E0;
         w_addr_nx  = '0;
         w_ph_nx    = 1'b0;
         w_bgp_nx   = 1'b0;
      end else if (w_op) begin
         w_ph_nx = w_el.two_ops && !r_ph;
         if (w_last_op) w_addr_nx = w_addr_step;
         if (w_last_op && w_wrap) begin
            w_addr_nx  = {ADDR_W{r_state inside {E2, E3}}};
            w_state_nx = (r_state != E5) ? state_t'(r_state + 4'd1) : (CB_EN && !r_bgp) ? E0 : DRAIN;
            w_bgp_nx   = r_bgp || (r_state == E5);
            w_dcnt_nx  = '0;
         end
      end else if (r_state == DRAIN) begin
         w_dcnt_nx  = r_dcnt + 2'd1;
         w_state_nx = (r_dcnt == DRAIN_LAST) ? DONE : DRAIN;
      end else if (r_state == DONE) begin
         w_state_nx = IDLE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= IDLE;
         r_addr   <= '0;
         r_ph     <= 1'b0;
         r_bgp    <= 1'b0;
         r_dcnt   <= '0;
         r_pass_q <= 1'b1;
      end else begin
         r_state <= w_state_nx;
         r_addr  <= w_addr_nx;
         r_ph    <= w_ph_nx;
         r_bgp   <= w_bgp_nx;
         r_dcnt  <= w_dcnt_nx;
         if (r_state == DONE) r_pass_q <= w_cmp_pass;
      end
   end

   sram_bist_cmp #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .READ_LAT (READ_LAT)
   ) u_cmp (
      .i_clk       (clk_i),
      .i_rst_n     (rst_ni),
      .i_clr       (w_start),
      .i_vld       (w_rd),
      .i_addr      (r_addr),
      .i_exp       (w_word),
      .i_dout      (bist_dout_i),
      .o_pass      (w_cmp_pass),
      .o_fail_addr (fail_addr_o),
      .o_fail_syn  (fail_syn_o)
   );

   assign busy_o      = w_op || (r_state == DRAIN);
   assign done_o      = r_state == DONE;
   assign pass_o      = done_o ? w_cmp_pass : r_pass_q;
   assign bist_en_o   = busy_o;
   assign bist_men_o  = w_op;
   assign bist_wen_o  = w_wr;
   assign bist_ren_o  = w_rd;
   assign bist_addr_o = w_op ? r_addr : '0;
   assign bist_din_o  = w_wr ? w_word : '0;
   assign bist_bm_o   = {DATA_W{w_op}};

endmodule

// File: tb/tb_sram_march_bist.sv
// tb_sram_march_bist: scoreboard bench for a 64x64 READ_LAT=1 engine with a faultable
// memory model, plus a 32x16 READ_LAT=2 engine whose address order is checked.
module tb_sram_march_bist;

`ifdef SRAM_BIST_CHECKERBOARD_EN
   localparam int PASSES = 2;
`else
   localparam int PASSES = 1;
`endif
   localparam int T_A = 10 * 64 * PASSES + 2;
   localparam int T_B = 10 * 16 * PASSES + 3;

   typedef struct {
      string       name;
      int          t0;
      logic        pass;
      logic [5:0]  addr;
      logic [63:0] syn;
   } exp_t;

   logic clk = 1'b0, rst_n = 1'b0, a_start = 1'b0, b_start = 1'b0;
   int   cyc = 0, n_chk = 0, n_err = 0;

   logic        a_busy, a_done, a_pass, a_en, a_men, a_wen, a_ren;
   logic [5:0]  a_faddr, a_addr;
   logic [63:0] a_fsyn, a_din, a_bm, a_dout;
   logic        b_busy, b_done, b_pass, b_en, b_men, b_wen, b_ren;
   logic [3:0]  b_faddr, b_addr;
   logic [31:0] b_fsyn, b_din, b_bm, b_d1, b_d2;

   sram_march_bist #(.DATA_W(64), .ADDR_W(6), .READ_LAT(1)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .start_i(a_start), .busy_o(a_busy), .done_o(a_done),
      .pass_o(a_pass), .fail_addr_o(a_faddr), .fail_syn_o(a_fsyn), .bist_en_o(a_en),
      .bist_men_o(a_men), .bist_wen_o(a_wen), .bist_ren_o(a_ren), .bist_addr_o(a_addr),
      .bist_din_o(a_din), .bist_bm_o(a_bm), .bist_dout_i(a_dout));

   sram_march_bist #(.DATA_W(32), .ADDR_W(4), .READ_LAT(2)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .start_i(b_start), .busy_o(b_busy), .done_o(b_done),
      .pass_o(b_pass), .fail_addr_o(b_faddr), .fail_syn_o(b_fsyn), .bist_en_o(b_en),
      .bist_men_o(b_men), .bist_wen_o(b_wen), .bist_ren_o(b_ren), .bist_addr_o(b_addr),
      .bist_din_o(b_din), .bist_bm_o(b_bm), .bist_dout_i(b_d2));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // 64x64 model: stuck-at-1 masks at two addresses and an optional coupling fault
   // that only fires when 0x10/0x11 hold the checkerboard background.
   logic [63:0] mem [64];
   logic [5:0]  f0_a = '0, f1_a = '0;
   logic [63:0] f0_m = '0, f1_m = '0;
   logic        cpl_en = 1'b0;
   int          n_wr = 0, n_rd = 0;

   function automatic logic [63:0] rd_word(input logic [5:0] a);
      logic [63:0] v = mem[a];
      logic [63:0] m10 = mem[6'h10];
      logic [63:0] m11 = mem[6'h11];
      if (a == f0_a) v |= f0_m;
      if (a == f1_a) v |= f1_m;
      if (cpl_en && a == 6'h11 && m10[1:0] == 2'b01 && m11[1:0] == 2'b10) v ^= 64'h8;
      return v;
   endfunction

   always @(posedge clk) begin
      if (a_start && !a_busy) begin
         n_wr <= 0;
         n_rd <= 0;
      end
      if (a_men && a_wen) begin
         mem[a_addr] <= (mem[a_addr] & ~a_bm) | (a_din & a_bm);
         n_wr <= n_wr + 1;
      end
      if (a_men && a_ren) begin
         a_dout <= rd_word(a_addr);
         n_rd <= n_rd + 1;
      end
   end

   logic [31:0] mem_b [16];
   logic [3:0]  seq [$];
   logic [3:0]  exp_seq [$];

   always @(posedge clk) begin
      if (b_men && b_wen) mem_b[b_addr] <= (mem_b[b_addr] & ~b_bm) | (b_din & b_bm);
      b_d1 <= mem_b[b_addr];
      b_d2 <= b_d1;
      if (b_start && !b_busy) seq.delete();
      if (b_men) seq.push_back(b_addr);
   end

   exp_t sb [$];
   int   sb_b [$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (a_done) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL a_unexpected_done: done_o=1 at cycle %0d, required no pulse", cyc);
            end else begin
               e = sb.pop_front();
               chk({e.name, "_done_cycle"}, 64'(cyc - e.t0), 64'(T_A));
               chk({e.name, "_pass"}, 64'(a_pass), 64'(e.pass));
               chk({e.name, "_fail_addr"}, 64'(a_faddr), 64'(e.addr));
               chk({e.name, "_fail_syn"}, a_fsyn, e.syn);
               chk({e.name, "_writes"}, 64'(n_wr), 64'(320 * PASSES));
               chk({e.name, "_reads"}, 64'(n_rd), 64'(320 * PASSES));
               chk({e.name, "_busy_at_done"}, 64'(a_busy), 64'(0));
            end
         end
      end
   end

   initial begin
      int t0;
      int bad;
      forever begin
         @(negedge clk);
         if (b_done) begin
            if (sb_b.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL b_unexpected_done: done_o=1 at cycle %0d, required no pulse", cyc);
            end else begin
               t0 = sb_b.pop_front();
               chk("b_done_cycle", 64'(cyc - t0), 64'(T_B));
               chk("b_pass", 64'(b_pass), 64'(1));
               chk("b_op_count", 64'(seq.size()), 64'(exp_seq.size()));
               bad = -1;
               for (int i = 0; i < seq.size() && i < exp_seq.size(); i++)
                  if (seq[i] !== exp_seq[i] && bad < 0) bad = i;
               chk("b_addr_seq_first_bad_index", 64'(bad), 64'(-1));
            end
         end
      end
   end

   task automatic run_a(input string nm, input logic ep, input logic [5:0] ea,
                        input logic [63:0] es, input int extra);
      int t0;
      @(posedge clk);
      #1 a_start = 1'b1;
      t0 = cyc;
      sb.push_back('{nm, t0, ep, ea, es});
      @(posedge clk);
      #1 a_start = 1'b0;
      if (extra > 0) begin
         while (cyc < t0 + extra) begin
            @(posedge clk);
            #1;
         end
         a_start = 1'b1;
         @(posedge clk);
         #1 a_start = 1'b0;
      end
      while (cyc < t0 + T_A + 3) begin
         @(posedge clk);
         #1;
      end
      chk({nm, "_scoreboard_drained"}, 64'(sb.size()), 64'(0));
   endtask

   initial begin
      int t0;
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pass", 64'(a_pass), 64'(1));
      chk("rst_busy", 64'(a_busy), 64'(0));
      chk("rst_done", 64'(a_done), 64'(0));
      chk("rst_bist_en", 64'(a_en), 64'(0));
      chk("rst_bm", a_bm, 64'(0));
      chk("rst_fail_syn", a_fsyn, 64'(0));
      rst_n = 1'b1;

      run_a("clean", 1'b1, 6'h00, 64'h0, 100);

      f0_a = 6'h2A;
      f0_m = 64'h20;
      run_a("sa1_2a", 1'b0, 6'h2A, 64'h20, 0);

      f1_a = 6'h03;
      f1_m = 64'h1;
      run_a("sa1_03_2a", 1'b0, 6'h03, 64'h1, 0);
      repeat (5) @(posedge clk);
      #1;
      chk("hold_pass", 64'(a_pass), 64'(0));
      chk("hold_fail_addr", 64'(a_faddr), 64'(6'h03));
      f0_m = '0;
      f1_m = '0;

      @(posedge clk);
      #1 a_start = 1'b1;
      t0 = cyc;
      @(posedge clk);
      #1 a_start = 1'b0;
      while (cyc < t0 + 300) begin
         @(posedge clk);
         #1;
      end
      chk("midtest_bist_en", 64'(a_en), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("rst_mid_en", 64'(a_en), 64'(0));
      chk("rst_mid_men", 64'(a_men), 64'(0));
      chk("rst_mid_wen_ren", 64'({a_wen, a_ren}), 64'(0));
      chk("rst_mid_addr", 64'(a_addr), 64'(0));
      chk("rst_mid_din", a_din, 64'(0));
      chk("rst_mid_bm", a_bm, 64'(0));
      chk("rst_mid_busy", 64'(a_busy), 64'(0));
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (700) @(posedge clk);

      cpl_en = 1'b1;
`ifdef SRAM_BIST_CHECKERBOARD_EN
      run_a("coupling", 1'b0, 6'h11, 64'h8, 0);
`else
      run_a("coupling", 1'b1, 6'h00, 64'h0, 0);
`endif

      for (int p = 0; p < PASSES; p++) begin
         for (int a = 0; a < 16; a++) exp_seq.push_back(4'(a));
         for (int k = 0; k < 2; k++) for (int a = 0; a < 16; a++) repeat (2) exp_seq.push_back(4'(a));
         for (int k = 0; k < 2; k++) for (int a = 15; a >= 0; a--) repeat (2) exp_seq.push_back(4'(a));
         for (int a = 0; a < 16; a++) exp_seq.push_back(4'(a));
      end
      @(posedge clk);
      #1 b_start = 1'b1;
      t0 = cyc;
      sb_b.push_back(t0);
      @(posedge clk);
      #1 b_start = 1'b0;
      while (cyc < t0 + T_B + 3) begin
         @(posedge clk);
         #1;
      end
      chk("b_scoreboard_drained", 64'(sb_b.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/sram_march_bist.md
Name: sram_march_bist

Overview:
- Parametrised March C- BIST engine for the single-port bit-masked SRAM macros (64x64 and larger).
- Drives the macro's BIST port group (BIST_EN/MEN/WEN/REN/ADDR/DIN/BM) and checks read data with a pipelined comparator.
- Reports pass/fail plus the first failing address and syndrome.
- One instance per macro, controlled from the test/DFT register block.

Parameters:
- DATA_W, 64, SRAM word width in bits.
- ADDR_W, 6, address width; depth N = 2**ADDR_W.
- READ_LAT, 1, cycles from read issue (REN sampled) to valid bist_dout_i; legal range 1..3.

Ports:
- clk_i  in  1  clock; also drives the macro's BIST clock.
- rst_ni  in  1  asynchronous reset, active-low.
- start_i  in  1  one-cycle start request.
- busy_o  out  1  test in progress.
- done_o  out  1  one-cycle pulse at end of test.
- pass_o  out  1  result of the last completed test.
- fail_addr_o  out  ADDR_W  address of the first miscompare.
- fail_syn_o  out  DATA_W  expected XOR actual at the first miscompare.
- bist_en_o  out  1  selects the BIST port in the macro.
- bist_men_o  out  1  memory enable.
- bist_wen_o  out  1  write enable.
- bist_ren_o  out  1  read enable.
- bist_addr_o  out  ADDR_W  address.
- bist_din_o  out  DATA_W  write data.
- bist_bm_o  out  DATA_W  bit mask; all ones during writes.
- bist_dout_i  in  DATA_W  read data from the macro.

Behaviour:
- Reset values: all outputs 0, except pass_o=1. State is IDLE.
- States: IDLE -> E0 -> E1 -> E2 -> E3 -> E4 -> E5 -> DRAIN -> DONE -> IDLE.
- March elements, with bg = background word (all zeros) and ~bg its complement:
  - E0 up (w bg)
  - E1 up (r bg, w ~bg)
  - E2 up (r ~bg, w bg)
  - E3 down (r bg, w ~bg)
  - E4 down (r ~bg, w bg)
  - E5 up (r bg)
- Issue rate: one operation per cycle, no bubbles.
  - Two-op elements alternate r/w at the same address, then increment or decrement the address.
  - "Up" runs 0..N-1; "down" runs N-1..0.
  - The address counter is ADDR_W bits and its wrap ends the element; no extra compare bit.
- On every op cycle: bist_en_o=bist_men_o=1, bist_bm_o all ones.
  - Read op: bist_ren_o=1, bist_wen_o=0.
  - Write op: bist_wen_o=1, bist_ren_o=0.
- Comparison: expected data and a valid flag travel through a READ_LAT-deep shift register.
  - When the delayed valid is high, bist_dout_i is compared against the delayed expected word.
  - First miscompare: capture fail_addr_o and fail_syn_o, clear the pass flag.
  - Later miscompares do not overwrite the capture. The test always runs to completion.
- DRAIN: READ_LAT cycles with MEN=WEN=REN=0 and bist_en_o still 1, so the final reads get compared.
- DONE: one cycle. done_o=1, pass_o updated, busy_o drops, bist_en_o=0. Returns to IDLE.
- Cycle count: start_i high at cycle 0 -> first op at cycle 1 -> done_o at cycle 10N + READ_LAT + 1. For N=64, READ_LAT=1: cycle 642.
- busy_o is high from cycle 1 to the end of DRAIN.
- start_i while busy_o=1: ignored.
- start_i in IDLE: clears the fail capture registers and sets the internal pass flag.
- pass_o and fail_* hold their values until the next accepted start.
- Reset mid-test: asynchronously returns to IDLE, all bist_* outputs to 0, no done_o pulse.

Optional Feature:
- Macro: SRAM_BIST_CHECKERBOARD_EN.
- Defined: after E5 completes with bg=0, the full E0..E5 sequence repeats with bg = alternating pattern starting with bit0=1 (0x5555... for 64 bits).
  - Inverted on odd addresses for a physical checkerboard.
  - DRAIN runs only once, at the end. Total cycles become 20N + READ_LAT + 1.
  - Fail capture spans both passes.
- Undefined: single solid-background pass only.

Decomposition:
- Package sram_bist_pkg:
  - state enum (IDLE, E0..E5, DRAIN, DONE)
  - per-element constants: direction, op count, read polarity, write polarity, as a localparam table indexed by element
  - background function of (pass, addr, DATA_W)
- One sub-module, sram_bist_cmp: READ_LAT-stage expected/valid pipeline plus first-fail capture.

Test Plan:
- Fault-free behavioural 64x64 model, start pulse -> done_o at cycle 642, pass_o=1, fail_syn_o=0, 320 writes and 320 reads counted.
- Model with bit 5 of address 0x2A stuck-at-1 -> pass_o=0, fail_addr_o=0x2A, fail_syn_o=0x20 (first failure in E1 r0).
- Second stuck fault at address 0x03 bit 0 in addition to 0x2A -> capture shows 0x03 (earlier ascending), and the later fault does not overwrite it.
- start_i pulsed again at cycle 100 -> ignored, done_o still at 642. rst_ni low at cycle 300 -> all bist_* outputs 0 immediately, no done_o. Restart completes normally.
- Parameters DATA_W=32, ADDR_W=4, READ_LAT=2 -> done at cycle 163. Down elements must visit addresses 15..0 in order.
- With SRAM_BIST_CHECKERBOARD_EN and a coupling fault that only triggers under the alternating pattern -> solid pass clean, fail captured in the second pass. Done at cycle 1282 for 64x64.
